// File: rtl/fp_operand_stage.sv
// FP operand-issue stage: classifies and optionally canonicalises rs1/rs2,
// then presents them through a registered two-entry skid buffer.
module fp_operand_stage #(
  parameter int OPW       = 3,
  parameter int CANON_NAN = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rs1,
  output logic [31:0]      out_rs2,
  output logic [OPW-1:0]   out_op,
  output logic [9:0]       out_cls1,
  output logic [9:0]       out_cls2,
  output logic             out_snan
);

  localparam int EW = 32 + 32 + OPW + 10 + 10 + 1;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[22];
  endfunction

  function automatic logic [9:0] fclass(input logic [31:0] x);
    logic       s;
    logic [7:0] e;
    logic       mz;
    logic [9:0] c;
    s  = x[31];
    e  = x[30:23];
    mz = (x[22:0] == 23'd0);
    c  = 10'd0;
    unique case (1'b1)
      (e == 8'hFF) && !mz && x[22]:  c = 10'h200;
      (e == 8'hFF) && !mz && !x[22]: c = 10'h100;
      (e == 8'hFF) && mz:            c = s ? 10'h001 : 10'h080;
      (e == 8'h00) && mz:            c = s ? 10'h008 : 10'h010;
      (e == 8'h00) && !mz:           c = s ? 10'h004 : 10'h020;
      default:                       c = s ? 10'h002 : 10'h040;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] canon(input logic [31:0] x);
    return ((CANON_NAN != 0) && is_nan(x)) ? QNAN : x;
  endfunction

  logic [1:0]    state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [EW-1:0] m_q, m_d;
  logic [EW-1:0] s_q, s_d;
  logic [EW-1:0] new_entry;
  logic          acc;
  logic          pop;

  assign acc = in_valid && in_ready_q;
  assign pop = out_valid_q && out_ready;

  // Classification is taken from the original bits, before canonicalisation.
  always_comb begin
    new_entry = {canon(in_rs1), canon(in_rs2), in_op,
                 fclass(in_rs1), fclass(in_rs2),
                 is_snan(in_rs1) || is_snan(in_rs2)};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          m_d     = new_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          m_d = new_entry;
        end else if (acc) begin
          s_d     = new_entry;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      m_q         <= '0;
      s_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      m_q         <= m_d;
      s_q         <= s_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign {out_rs1, out_rs2, out_op, out_cls1, out_cls2, out_snan} = m_q;

endmodule

// File: tb/tb_fp_operand_stage.sv
// Bench for fp_operand_stage: scoreboard of expected entries popped on
// every output transfer, plus directed checks of handshake and reset.
module tb_fp_operand_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rs1, in_rs2;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1, out_rs2;
  logic [2:0]  out_op;
  logic [9:0]  out_cls1, out_cls2;
  logic        out_snan;

  int errors = 0;
  int checks = 0;
  int outs   = 0;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  op;
    logic [9:0]  c1;
    logic [9:0]  c2;
    logic        snan;
  } exp_t;

  exp_t sb[$];

  fp_operand_stage #(.OPW(3), .CANON_NAN(1)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_op(out_op),
    .out_cls1(out_cls1), .out_cls2(out_cls2), .out_snan(out_snan)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ref_class(input logic [31:0] x);
    logic [7:0]  e;
    logic [22:0] m;
    e = x[30:23];
    m = x[22:0];
    if (e == 8'hFF && m != 0) return m[22] ? 10'h200 : 10'h100;
    if (e == 8'hFF)           return x[31] ? 10'h001 : 10'h080;
    if (e == 0 && m == 0)     return x[31] ? 10'h008 : 10'h010;
    if (e == 0)               return x[31] ? 10'h004 : 10'h020;
    return x[31] ? 10'h002 : 10'h040;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op);
    exp_t r;
    r.c1   = ref_class(a);
    r.c2   = ref_class(b);
    r.rs1  = r.c1[9:8] != 0 ? 32'h7FC00000 : a;
    r.rs2  = r.c2[9:8] != 0 ? 32'h7FC00000 : b;
    r.op   = op;
    r.snan = r.c1[8] | r.c2[8];
    return r;
  endfunction

  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      exp_t e;
      outs++;
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(out_rs1), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check("out_rs1", 64'(out_rs1), 64'(e.rs1));
        check("out_rs2", 64'(out_rs2), 64'(e.rs2));
        check("out_op", 64'(out_op), 64'(e.op));
        check("out_cls1", 64'(out_cls1), 64'(e.c1));
        check("out_cls2", 64'(out_cls2), 64'(e.c2));
        check("out_snan", 64'(out_snan), 64'(e.snan));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op);
    int n;
    in_valid = 1'b1;
    in_rs1   = a;
    in_rs2   = b;
    in_op    = op;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("send_timeout", 64'(in_ready), 64'd1);
    sb.push_back(model(a, b, op));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cyc);
    in_valid = 1'b0;
    in_rs1   = 'x;
    in_rs2   = 'x;
    in_op    = 'x;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    #1;
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [31:0] specials [8];
  initial begin
    specials[0] = 32'h7F800001; specials[1] = 32'hFFC00000;
    specials[2] = 32'h80000000; specials[3] = 32'h00000000;
    specials[4] = 32'h807FFFFF; specials[5] = 32'hFF800000;
    specials[6] = 32'h7F800000; specials[7] = 32'hFFA00000;
  end

  initial begin
    int base;
    logic [31:0] a, b;
    resetn    = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_rs1    = 32'h3F800000;
    in_rs2    = 32'h3F800000;
    in_op     = 3'd1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_rs1", 64'(out_rs1), 64'd0);
    check("rst_out_rs2", 64'(out_rs2), 64'd0);
    check("rst_out_op", 64'(out_op), 64'd0);
    check("rst_cls", 64'({out_cls1, out_cls2, out_snan}), 64'd0);
    in_valid = 1'b0;
    resetn   = 1'b1;
    idle(2);
    check("idle_out_valid", 64'(out_valid), 64'd0);

    send(32'h3F800000, 32'hBF800000, 3'd2);
    in_valid = 1'b0;
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_cls1", 64'(out_cls1), 64'h040);
    check("t2_cls2", 64'(out_cls2), 64'h002);
    check("t2_snan", 64'(out_snan), 64'd0);
    idle(2);

    send(32'h7F800001, 32'h00000001, 3'd3);
    in_valid = 1'b0;
    check("t3_rs1", 64'(out_rs1), 64'h7FC00000);
    check("t3_cls1", 64'(out_cls1), 64'h100);
    check("t3_cls2", 64'(out_cls2), 64'h020);
    check("t3_snan", 64'(out_snan), 64'd1);
    idle(2);

    out_ready = 1'b0;
    send(32'h40000000, 32'hC0000000, 3'd4);
    send(32'h40400000, 32'hC0400000, 3'd5);
    idle(1);
    check("t4_in_ready_full", 64'(in_ready), 64'd0);
    check("t4_out_valid", 64'(out_valid), 64'd1);
    check("t4_head_a", 64'(out_rs1), 64'h40000000);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t4_next_valid", 64'(out_valid), 64'd1);
    check("t4_head_b", 64'(out_rs1), 64'h40400000);
    check("t4_in_ready_back", 64'(in_ready), 64'd1);
    drain();
    check("t4_in_ready_end", 64'(in_ready), 64'd1);

    base = outs;
    for (int i = 0; i < 20; i++) begin
      a = (i % 3 == 0) ? specials[i % 8] : $urandom;
      b = (i % 4 == 1) ? specials[(i + 3) % 8] : $urandom;
      send(a, b, 3'(i));
      check("t5_in_ready", 64'(in_ready), 64'd1);
      check("t5_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    drain();
    check("t5_count", 64'(outs - base), 64'd20);

    out_ready = 1'b0;
    send(32'h11111111, 32'h22222222, 3'd6);
    send(32'h33333333, 32'h44444444, 3'd7);
    in_valid = 1'b0;
    resetn   = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    check("t6_out_rs1", 64'(out_rs1), 64'd0);
    out_ready = 1'b1;
    base = outs;
    idle(4);
    check("t6_no_stale", 64'(outs - base), 64'd0);
    send(32'hFF800000, 32'h80000000, 3'd1);
    in_valid = 1'b0;
    drain();
    check("t6_recover", 64'(outs - base), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
